// File: rtl/logic_pkg.sv
// Shared opcode definitions for the logic unit.
package logic_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation plus reduction flags of its result.
module logic_op_core
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic             zero
);

  // Opcode decode to the selected bitwise function.
  always_comb begin
    res = '0;
    unique case (op_e'(op))
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOT:  res = ~a;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_PASS: res = b;
      default: res = '0;
    endcase
  end

  // Reductions of the same value that gets registered as the result.
  always_comb begin
    red_and = &res;
    red_or  = |res;
    red_xor = ^res;
    zero    = ~(|res);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: one-deep valid/ready stage, accumulator, op counter.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic             zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] core_res;
  logic             core_and, core_or, core_xor, core_zero;

  // Handshake and effective A operand; clr zeroes the operand only when chaining.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    a_eff    = a;
    if (acc_en) a_eff = acc_clr ? '0 : acc;
  end

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op      (op),
    .a       (a_eff),
    .b       (b),
    .res     (core_res),
    .red_and (core_and),
    .red_or  (core_or),
    .red_xor (core_xor),
    .zero    (core_zero)
  );

  // Result register with flags and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      red_and   <= 1'b0;
      red_or    <= 1'b0;
      red_xor   <= 1'b0;
      zero      <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= core_res;
      red_and   <= core_and;
      red_or    <= core_or;
      red_xor   <= core_xor;
      zero      <= core_zero;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator: a chained accept wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && acc_en) begin
      acc <= core_res;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  // Saturating count of accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (accept && (op_count != '1)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       acc_en = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       red_and, red_or, red_xor, zero;
  logic [7:0] acc;
  logic [3:0] op_count;

  int total = 0;
  int bad = 0;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor),
    .zero      (zero),
    .acc       (acc),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int f_op(input int o, input int x, input int y);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return 255 - x;
      3: return 255 - (x & y);
      4: return 255 - (x | y);
      5: return x ^ y;
      6: return 255 - (x ^ y);
      default: return y;
    endcase
  endfunction

  function automatic int ones(input int v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (((v >> i) & 1) == 1) n++;
    return n;
  endfunction

  int m_res = 0;
  int m_acc = 0;
  int m_cnt = 0;
  int m_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res <= 0; m_acc <= 0; m_cnt <= 0; m_valid <= 0;
    end else begin
      if (in_valid && (m_valid == 0 || out_ready)) begin
        int opa, r;
        opa = acc_en ? (acc_clr ? 0 : m_acc) : int'(a);
        r = f_op(int'(op), opa, int'(b));
        m_res   <= r;
        m_valid <= 1;
        m_cnt   <= (m_cnt < 15) ? m_cnt + 1 : 15;
        if (acc_en) m_acc <= r;
        else if (acc_clr) m_acc <= 0;
      end else begin
        if (out_ready) m_valid <= 0;
        if (acc_clr) m_acc <= 0;
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    chk("m_in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
    chk("m_out_valid", int'(out_valid), m_valid);
    chk("m_result", int'(result), m_res);
    chk("m_red_and", int'(red_and), (ones(m_res) == 8) ? 1 : 0);
    chk("m_red_or", int'(red_or), (ones(m_res) > 0) ? 1 : 0);
    chk("m_red_xor", int'(red_xor), ones(m_res) % 2);
    chk("m_zero", int'(zero), (m_res == 0) ? 1 : 0);
    chk("m_acc", int'(acc), m_acc);
    chk("m_op_count", int'(op_count), m_cnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic beat(input int o, input int x, input int y, input bit en, input bit clr);
    in_valid = 1'b1; op = 3'(o); a = 8'(x); b = 8'(y); acc_en = en; acc_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int sweep_exp [8] = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A};
    int snap;

    do_reset();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_zero", int'(zero), 1);
    chk("rst_op_count", int'(op_count), 0);

    // Opcode sweep, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(i, 8'hC5, 8'h3A, 1'b0, 1'b0);
      chk("sweep_result", int'(result), sweep_exp[i]);
      chk("sweep_valid", int'(out_valid), 1);
      chk("sweep_in_ready", int'(in_ready), 1);
      if (i == 0) begin
        chk("and_zero", int'(zero), 1);
        chk("and_red_or", int'(red_or), 0);
      end
      if (i == 5) begin
        chk("xor_red_and", int'(red_and), 1);
        chk("xor_red_xor", int'(red_xor), 0);
      end
    end
    chk("sweep_count", int'(op_count), 8);

    // Backpressure: one accept, then 3 stalled cycles, then release.
    beat(1, 8'h12, 8'h40, 1'b0, 1'b0);            // OR -> 52
    snap = int'(op_count);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd5; a = 8'hAA; b = 8'h0F; // XOR -> A5
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_result", int'(result), 8'h52);
      @(posedge clk); #1;
    end
    chk("bp_count_hold", int'(op_count), snap);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_result", int'(result), 8'hA5);
    chk("bp_release_count", int'(op_count), snap + 1);
    idle();
    @(posedge clk); #1;
    chk("bp_drained_valid", int'(out_valid), 0);
    chk("bp_no_dup_count", int'(op_count), snap + 1);

    // Accumulator chain.
    beat(1, 8'hFF, 8'h0F, 1'b1, 1'b1);
    chk("acc1_result", int'(result), 8'h0F);
    chk("acc1_acc", int'(acc), 8'h0F);
    beat(5, 8'h00, 8'hFF, 1'b1, 1'b0);
    chk("acc2_result", int'(result), 8'hF0);
    chk("acc2_acc", int'(acc), 8'hF0);
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b1;
    @(posedge clk); #1;
    chk("acc3_acc", int'(acc), 8'h00);
    chk("acc3_result_hold", int'(result), 8'hF0);
    idle();

    // Asynchronous reset mid-stream with a result pending.
    out_ready = 1'b0;
    beat(1, 8'h81, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_result", int'(result), 0);
    chk("async_zero", int'(zero), 1);
    chk("async_acc", int'(acc), 0);
    chk("async_op_count", int'(op_count), 0);
    chk("async_in_ready", int'(in_ready), 1);
    idle();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Counter saturation with some stalled cycles mixed in.
    for (int i = 0; i < 20; i++) begin
      beat(7, 0, i, 1'b0, 1'b0);
      if (i == 4) begin
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    end
    idle();
    @(posedge clk); #1;
    chk("sat_count", int'(op_count), 15);
    beat(0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("sat_hold", int'(op_count), 15);

    // Random traffic, checked every cycle by the model compare.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      acc_en    = 1'($urandom_range(0, 1));
      acc_clr   = ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
    end
    idle();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the combinational two-input gate set. The block applies one of eight bitwise logic operations to WIDTH-bit operands and registers the result behind a valid/ready handshake. It adds three things the gate set does not have: an accumulator that can replace operand A for chained operations, reduction flags on the result, and a saturating count of completed operations. It sits between an operand source and a result consumer in datapath test structures.

## Interface
Parameters:
- WIDTH, 8, operand and result width (≥1)
- CNT_W, 8, width of the operation counter (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept the beat
- op  in  3  opcode
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- acc_en  in  1  use the accumulator instead of `a`; write the result back to the accumulator
- acc_clr  in  1  clear the accumulator (takes effect regardless of in_valid)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- red_and, red_or, red_xor  out  1  reductions of `result`, registered with it
- zero  out  1  `result == 0`
- acc  out  WIDTH  current accumulator value
- op_count  out  CNT_W  number of accepted beats, saturating

## Operation
- Opcodes:
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 NOT: ~A (B ignored)
  - 3 NAND: ~(A&B)
  - 4 NOR: ~(A|B)
  - 5 XOR: A^B
  - 6 XNOR: ~(A^B)
  - 7 PASS: B
- Effective A operand:
  - acc_en=0: A = a.
  - acc_en=1: A = acc. If acc_clr is high in the same cycle, A = 0.
- Accept: a beat is accepted when in_valid && in_ready.
- Result register: on accept, the opcode result loads into result, and all flags are computed from that same value. out_valid is set on the same edge.
- Output handshake:
  - in_ready = !out_valid || out_ready. One-deep pipeline; no skid buffer.
  - When out_valid && out_ready with no new accept, out_valid clears. result holds its last value.
- Accumulator update, in priority order:
  1. accept with acc_en=1: acc ← result of that beat (this overrides acc_clr; clr only affects the operand).
  2. otherwise acc_clr=1: acc ← 0.
  3. otherwise acc holds.
- Counter: op_count increments on each accept and holds at 2^CNT_W−1. It is not cleared by acc_clr.
- Reset values: in_ready=1, out_valid=0, result=0, red_and=0, red_or=0, red_xor=0, zero=1, acc=0, op_count=0.
- Reset mid-operation: any result not yet taken is discarded, and every output returns to its reset value immediately (asynchronous).

## Timing
- Latency is 1 cycle: a beat accepted at edge N gives out_valid=1 and result after edge N.
- Full throughput: a new beat is accepted every cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. result, flags and acc hold, and no accept occurs.
- Simultaneous consume and accept (out_valid && out_ready && in_valid): result is replaced, and out_valid stays 1.
- Accumulator chaining: back-to-back acc_en beats see acc updated from the previous beat, with no bubble.
- in_ready depends combinationally on out_ready. There are no other combinational input→output paths.
- Reset deassertion is assumed synchronised externally.

## Structure
- Shared package logic_pkg holds:
  - opcode constants OP_AND … OP_PASS (3-bit)
  - the opcode width constant
- Sub-module logic_op_core: purely combinational. Takes (op, A, B) and produces the WIDTH-bit result plus the four flags. The top level owns the handshake, accumulator and counter registers.
- Expected size: roughly 150–250 lines total.

## Test plan
All scenarios use WIDTH=8, CNT_W=4.
- Reset: assert rst_n=0 mid-stream with out_valid=1 → all outputs return to reset values at once; zero=1, op_count=0.
- Opcode sweep: a=8'hC5, b=8'h3A, all 8 ops with out_ready=1 → results are 00, FF, 3A, FF, 00, FF, 00, 3A.
  - For AND: zero=1, red_or=0.
  - For XOR: red_and=1, red_xor=0.
  - Throughput is one result per cycle.
- Backpressure: hold out_ready=0 for 3 cycles after one accept → in_ready=0, result stable. Release → the next beat is accepted on the release cycle, with no lost or duplicated beat.
- Accumulator chain:
  - Step 1: acc_clr=1, acc_en=1, op=OR, b=8'h0F → result 0F, acc=0F.
  - Step 2: op=XOR, b=8'hFF, acc_en=1 → result F0, acc=F0.
  - Step 3: acc_clr alone, no valid → acc=00.
- Counter saturation: 20 accepted beats → op_count reads 15 and holds. Non-accepted cycles with in_valid=1 and in_ready=0 do not count.
- Random: constrained-random op/a/b/valid/ready against a reference model → result, flags, acc and op_count match every cycle.
